// File: rtl/main.sv
// main: UART 8N1 receiver and transmitter on one clock, with traffic routing selected by in_mode.
// Optional macro FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame echoed in mode 11.
module main #(
  parameter int unsigned BPS          = 24,
  parameter int unsigned MESSAGE_SIZE = 1,
  parameter int unsigned CLKS_PER_BIT = 640
) (
  input  logic                    in_clk,
  input  logic                    in_reset,
  input  logic                    rx_serial,
  input  logic [MESSAGE_SIZE-1:0] in_message,
  input  logic [1:0]              in_mode,
  output logic                    tx_serial,
  output logic                    tx_done
);

  localparam int unsigned NBytes = BPS / 8;
  localparam int unsigned FrameW = BPS + 8;
  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AsmW   = $clog2(NBytes + 1);
  localparam int unsigned SendW  = $clog2(NBytes + 2);

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AsmW-1:0] LastByte = AsmW'(NBytes - 1);

  localparam logic [1:0] ModeMsg  = 2'b01;
  localparam logic [1:0] ModeLoop = 2'b10;
  localparam logic [1:0] ModeEcho = 2'b11;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // Input synchronizer
  logic rx_meta_q, rx_sync_q;

  // Receiver
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;

  // Transmitter and holding register
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_serial_q, tx_serial_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_take;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            hold_accept, hold_load;
  logic [7:0]      hold_byte;

  // Mode control and frame buffers
  logic [1:0]        mode_q, mode_d;
  logic              mode_change;
  logic [BPS-1:0]    asm_q, asm_d, asm_next;
  logic [AsmW-1:0]   asm_cnt_q, asm_cnt_d;
  logic [BPS-1:0]    pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [SendW-1:0]  send_cnt_q, send_cnt_d;
  logic [7:0]        csum;

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned EchoBytes = NBytes + 1;

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < int'(NBytes); i++) begin
      csum = csum ^ pend_q[i*8 +: 8];
    end
  end
`else
  localparam int unsigned EchoBytes = NBytes;

  assign csum = 8'h00;
`endif

  // ---------------------------------------------------------------- receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        // Line must still be low at mid start bit, otherwise treat it as a glitch
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_sync_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ------------------------------------------------------------- transmitter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_take    = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (hold_full_q) begin
          tx_take    = 1'b1;
          tx_shift_d = hold_q;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
        end
      end
      TxStop: begin
        // Chain straight into the next start bit so bytes go out with no idle gap
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (hold_full_q) begin
            tx_take    = 1'b1;
            tx_shift_d = hold_q;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    unique case (tx_state_d)
      TxStart: tx_serial_d = 1'b0;
      TxData:  tx_serial_d = tx_shift_d[0];
      default: tx_serial_d = 1'b1;
    endcase
    tx_done_d = (tx_state_d == TxStop) && (tx_cnt_d == BitLast);
  end

  assign hold_accept = !hold_full_q || tx_take;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (tx_take) hold_full_d = 1'b0;
    if (hold_load && hold_accept) begin
      hold_d      = hold_byte;
      hold_full_d = 1'b1;
    end
  end

  // ------------------------------------------------------------ mode routing
  assign mode_change = (tx_state_q == TxIdle) && !hold_full_q && (in_mode != mode_q);
  assign asm_next    = (asm_q >> 8) | (BPS'(rx_shift_q) << (BPS - 8));

  always_comb begin
    mode_d       = mode_q;
    asm_d        = asm_q;
    asm_cnt_d    = asm_cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    frame_d      = frame_q;
    send_cnt_d   = send_cnt_q;
    hold_load    = 1'b0;
    hold_byte    = 8'h00;
    if (mode_change) begin
      mode_d       = in_mode;
      asm_d        = '0;
      asm_cnt_d    = '0;
      pend_valid_d = 1'b0;
      send_cnt_d   = '0;
      if (in_mode == ModeMsg) begin
        frame_d    = FrameW'(in_message);
        send_cnt_d = SendW'(NBytes);
      end
    end else begin
      if (mode_q == ModeLoop && rx_valid_q) begin
        hold_load = 1'b1;
        hold_byte = rx_shift_q;
      end

      if (send_cnt_q != '0) begin
        if (hold_accept) begin
          hold_load  = 1'b1;
          hold_byte  = frame_q[7:0];
          frame_d    = frame_q >> 8;
          send_cnt_d = send_cnt_q - SendW'(1);
        end
      end else if (pend_valid_q) begin
        frame_d      = {csum, pend_q};
        send_cnt_d   = SendW'(EchoBytes);
        pend_valid_d = 1'b0;
      end

      // A completed frame parks in pend_q so assembly of the next one never stalls
      if (mode_q == ModeEcho && rx_valid_q) begin
        if (asm_cnt_q == LastByte) begin
          pend_d       = asm_next;
          pend_valid_d = 1'b1;
          asm_d        = '0;
          asm_cnt_d    = '0;
        end else begin
          asm_d     = asm_next;
          asm_cnt_d = asm_cnt_q + AsmW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_valid_q   <= 1'b0;
      tx_state_q   <= TxIdle;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_serial_q  <= 1'b1;
      tx_done_q    <= 1'b0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      mode_q       <= 2'b00;
      asm_q        <= '0;
      asm_cnt_q    <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      frame_q      <= '0;
      send_cnt_q   <= '0;
    end else begin
      rx_meta_q    <= rx_serial;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_valid_q   <= rx_valid_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_serial_q  <= tx_serial_d;
      tx_done_q    <= tx_done_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      mode_q       <= mode_d;
      asm_q        <= asm_d;
      asm_cnt_q    <= asm_cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      frame_q      <= frame_d;
      send_cnt_q   <= send_cnt_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_main.sv
// tb_main: directed bench for the UART link; decodes tx_serial and compares against hand-computed bytes.
// Runs with a short bit period to keep the simulation small.
`timescale 1ns/1ps
module tb_main;

  localparam int unsigned CPB = 16;
  localparam int unsigned BPS = 24;

  logic       in_clk     = 1'b0;
  logic       in_reset   = 1'b1;
  logic       rx_serial  = 1'b1;
  logic [0:0] in_message = 1'b0;
  logic [1:0] in_mode    = 2'b00;
  logic       tx_serial;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  seen[$];
  int unsigned start_cyc[$];
  int unsigned done_cyc[$];

  logic [7:0] b2b [18] = '{8'h3F, 8'h03, 8'h33, 8'hFF, 8'hE4, 8'hB7, 8'hA9, 8'hB1, 8'hC5,
                           8'hF1, 8'h1F, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'h12, 8'h34, 8'h56};

  main #(
    .BPS         (BPS),
    .MESSAGE_SIZE(1),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .in_clk    (in_clk),
    .in_reset  (in_reset),
    .rx_serial (rx_serial),
    .in_message(in_message),
    .in_mode   (in_mode),
    .tx_serial (tx_serial),
    .tx_done   (tx_done)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc.push_back(cyc);
    end
  end

  // Decode tx_serial, sampling each bit at its centre
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge in_clk);
      if (in_reset === 1'b1 && tx_serial === 1'b0) begin
        start_cyc.push_back(cyc);
        repeat (CPB / 2) @(negedge in_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge in_clk);
          b[i] = tx_serial;
        end
        repeat (CPB) @(negedge in_clk);
        seen.push_back(b);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(negedge in_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx_serial = 1'b1;
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget,
                           output bit timed_out);
    int unsigned n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge in_clk);
      n++;
    end
    timed_out = (done_cnt < target);
  endtask

  task automatic test_reset();
    #1 in_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge in_clk);
      total++;
      if (tx_serial !== 1'b1 || tx_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: cycle %0d got tx_serial=%b tx_done=%b want 1/0",
                 i, tx_serial, tx_done);
      end
    end
    in_reset = 1'b1;
    repeat (5) @(negedge in_clk);
    total++;
    if (tx_serial !== 1'b1 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got tx_serial=%b tx_done=%b want 1/0", tx_serial, tx_done);
    end
  endtask

  task automatic test_idle_mode();
    int sidx;
    int unsigned d0;
    sidx = seen.size();
    d0   = done_cnt;
    send_byte(8'h55, 1'b1);
    repeat (30 * CPB) @(negedge in_clk);
    total++;
    if (seen.size() != sidx) begin
      bad++;
      $display("FAIL idle_no_tx: got %0d bytes want 0", seen.size() - sidx);
    end
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("FAIL idle_no_done: got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_loopback();
    int sidx;
    int unsigned d0, n, lo, hi, lo2;
    bit to;
    in_mode = 2'b10;
    repeat (4) @(negedge in_clk);
    sidx = seen.size();
    d0   = done_cnt;
    n = 0; lo = 0; hi = 0; lo2 = 0;
    fork
      send_byte(8'h3F, 1'b1);
      begin
        while (tx_serial !== 1'b0 && n < 40 * CPB) begin @(negedge in_clk); n++; end
        while (tx_serial === 1'b0 && lo < 20 * CPB) begin @(negedge in_clk); lo++; end
        while (tx_serial === 1'b1 && hi < 20 * CPB) begin @(negedge in_clk); hi++; end
        while (tx_serial === 1'b0 && lo2 < 20 * CPB) begin @(negedge in_clk); lo2++; end
      end
    join
    total++;
    if (n >= 40 * CPB) begin
      bad++;
      $display("FAIL loop_start_timeout: no start bit within %0d cycles", 40 * CPB);
    end
    total++;
    if (lo != CPB) begin
      bad++;
      $display("FAIL loop_start_width: got %0d cycles want %0d", lo, CPB);
    end
    total++;
    if (hi != 6 * CPB) begin
      bad++;
      $display("FAIL loop_ones_width: got %0d cycles want %0d", hi, 6 * CPB);
    end
    total++;
    if (lo2 != 2 * CPB) begin
      bad++;
      $display("FAIL loop_zeros_width: got %0d cycles want %0d", lo2, 2 * CPB);
    end
    wait_done(d0 + 1, 20 * CPB, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL loop_done_timeout: got %0d pulses want 1", done_cnt - d0);
    end
    repeat (4 * CPB) @(negedge in_clk);
    total++;
    if (seen.size() != sidx + 1 || seen[sidx] !== 8'h3F) begin
      bad++;
      $display("FAIL loop_byte: got %0d bytes first=%h want 1 byte 3f",
               seen.size() - sidx, (seen.size() > sidx) ? seen[sidx] : 8'hxx);
    end
    total++;
    if (done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL loop_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_frame_echo();
    int sidx;
    int unsigned d0;
    bit to;
    logic [7:0] exp[$];
    exp = '{8'h3F, 8'h03, 8'h33};
`ifdef FRAME_CHECKSUM_EN
    exp.push_back(8'h0F);
`endif
    in_mode = 2'b11;
    repeat (4) @(negedge in_clk);
    sidx = seen.size();
    d0   = done_cnt;
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1);
    wait_done(d0 + exp.size(), (exp.size() + 2) * 10 * CPB, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL echo_done_timeout: got %0d pulses want %0d", done_cnt - d0, exp.size());
    end
    repeat (20 * CPB) @(negedge in_clk);
    total++;
    if (done_cnt != d0 + exp.size() || seen.size() != sidx + exp.size()) begin
      bad++;
      $display("FAIL echo_count: got %0d pulses %0d bytes want %0d",
               done_cnt - d0, seen.size() - sidx, exp.size());
    end
    for (int k = 0; k < exp.size() && sidx + k < seen.size(); k++) begin
      total++;
      if (seen[sidx+k] !== exp[k]) begin
        bad++;
        $display("FAIL echo_byte%0d: got %h want %h", k, seen[sidx+k], exp[k]);
      end
    end
    for (int k = 1; k < exp.size() && sidx + k < start_cyc.size(); k++) begin
      total++;
      if (start_cyc[sidx+k] != done_cyc[d0+k-1] + 1) begin
        bad++;
        $display("FAIL echo_gap%0d: got start at %0d want %0d", k, start_cyc[sidx+k],
                 done_cyc[d0+k-1] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sidx;
    int unsigned d0;
    bit to;
    logic [7:0] exp[$];
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < 3; j++) exp.push_back(b2b[f*3+j]);
`ifdef FRAME_CHECKSUM_EN
      exp.push_back(b2b[f*3] ^ b2b[f*3+1] ^ b2b[f*3+2]);
`endif
    end
    sidx = seen.size();
    d0   = done_cnt;
    for (int i = 0; i < 18; i++) send_byte(b2b[i], 1'b1);
    wait_done(d0 + exp.size(), 12 * 10 * CPB, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL b2b_done_timeout: got %0d pulses want %0d", done_cnt - d0, exp.size());
    end
    repeat (20 * CPB) @(negedge in_clk);
    total++;
    if (done_cnt != d0 + exp.size() || seen.size() != sidx + exp.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d pulses %0d bytes want %0d",
               done_cnt - d0, seen.size() - sidx, exp.size());
    end
    for (int k = 0; k < exp.size() && sidx + k < seen.size(); k++) begin
      total++;
      if (seen[sidx+k] !== exp[k]) begin
        bad++;
        $display("FAIL b2b_byte%0d: got %h want %h", k, seen[sidx+k], exp[k]);
      end
    end
  endtask

  task automatic test_message();
    int sidx;
    int unsigned d0;
    bit to;
    logic [7:0] exp [3] = '{8'h01, 8'h00, 8'h00};
    sidx = seen.size();
    d0   = done_cnt;
    in_message = 1'b1;
    in_mode    = 2'b01;
    wait_done(d0 + 3, 50 * CPB, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL msg_done_timeout: got %0d pulses want 3", done_cnt - d0);
    end
    repeat (40 * CPB) @(negedge in_clk);
    total++;
    if (done_cnt != d0 + 3 || seen.size() != sidx + 3) begin
      bad++;
      $display("FAIL msg_once: got %0d pulses %0d bytes want 3", done_cnt - d0,
               seen.size() - sidx);
    end
    for (int k = 0; k < 3 && sidx + k < seen.size(); k++) begin
      total++;
      if (seen[sidx+k] !== exp[k]) begin
        bad++;
        $display("FAIL msg_byte%0d: got %h want %h", k, seen[sidx+k], exp[k]);
      end
    end
    in_mode = 2'b00;
    repeat (10) @(negedge in_clk);
    in_mode = 2'b01;
    wait_done(d0 + 6, 50 * CPB, to);
    repeat (2 * CPB) @(negedge in_clk);
    total++;
    if (to || seen.size() != sidx + 6 || seen[sidx+3] !== 8'h01) begin
      bad++;
      $display("FAIL msg_resend: got %0d pulses %0d bytes want 6", done_cnt - d0,
               seen.size() - sidx);
    end
  endtask

  task automatic test_glitch();
    int sidx;
    int unsigned d0;
    bit to;
    in_mode = 2'b10;
    repeat (4) @(negedge in_clk);
    sidx = seen.size();
    d0   = done_cnt;
    rx_serial = 1'b0;
    repeat (CPB / 4) @(negedge in_clk);
    rx_serial = 1'b1;
    repeat (20 * CPB) @(negedge in_clk);
    total++;
    if (seen.size() != sidx || done_cnt != d0) begin
      bad++;
      $display("FAIL glitch_rejected: got %0d bytes %0d pulses want 0", seen.size() - sidx,
               done_cnt - d0);
    end
    send_byte(8'hA5, 1'b0);
    repeat (30 * CPB) @(negedge in_clk);
    total++;
    if (seen.size() != sidx || done_cnt != d0) begin
      bad++;
      $display("FAIL framing_rejected: got %0d bytes %0d pulses want 0", seen.size() - sidx,
               done_cnt - d0);
    end
    send_byte(8'h5A, 1'b1);
    wait_done(d0 + 1, 30 * CPB, to);
    repeat (4 * CPB) @(negedge in_clk);
    total++;
    if (to || seen.size() != sidx + 1 || seen[sidx] !== 8'h5A) begin
      bad++;
      $display("FAIL recover_byte: got %0d bytes want 1 byte 5a", seen.size() - sidx);
    end
  endtask

  initial begin
    test_reset();
    test_idle_mode();
    test_loopback();
    test_frame_echo();
    test_back_to_back();
    test_message();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
